// File: rtl/input_setup_skewer.sv
// Loads an N x N activation tile from the unified buffer, then streams it with diagonal skew into the array.
// Optional macro INPUT_SETUP_SAT_EN: saturate over-wide elements and raise a sticky ovf flag.
module input_setup_skewer #(
  parameter int N      = 2,
  parameter int DATA_W = 16,
  parameter int MEM_W  = 32,
  parameter int ADDR_W = 13,
  parameter int FLUSH  = N
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                stall,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [MEM_W-1:0]    rd_data,
  output logic [N*DATA_W-1:0] a_out,
  output logic                a_valid,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  // Stream lasts N+FLUSH cycles: lane 0 delivers N elements, then FLUSH zero cycles.
  localparam int S  = N + FLUSH;
  localparam int NN = N * N;
  localparam int TW = $clog2(2 * N + FLUSH + 1);
  localparam int IW = $clog2(NN + 1);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_t;

  state_t              state_q, state_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [IW-1:0]       issue_q, issue_d;
  logic                rd_pend_q, rd_pend_d;
  logic [CW-1:0]       cap_r_q, cap_r_d;
  logic [CW-1:0]       cap_c_q, cap_c_d;
  logic [TW-1:0]       t_q, t_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   elem_in;
  logic [DATA_W-1:0]   tile [N][N];

`ifdef INPUT_SETUP_SAT_EN
  logic hi_nz;
  logic ovf_q, ovf_d;

  assign hi_nz   = |rd_data[MEM_W-1:DATA_W];
  assign elem_in = hi_nz ? {DATA_W{1'b1}} : rd_data[DATA_W-1:0];

  always_comb begin
    ovf_d = ovf_q | (rd_pend_q & hi_nz);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_hi;

  assign unused_hi = |rd_data[MEM_W-1:DATA_W];
  assign elem_in   = rd_data[DATA_W-1:0];
  assign ovf       = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    issue_d   = issue_q;
    rd_pend_d = rd_en_q;
    cap_r_d   = cap_r_q;
    cap_c_d   = cap_c_q;
    t_d       = t_q;
    done_d    = 1'b0;

    // Read data lands one cycle after the strobe; capture runs independently of state so the
    // final word may arrive in the first STREAM cycle, well before its lane needs it.
    if (rd_pend_q) begin
      if (cap_c_q == CW'(N - 1)) begin
        cap_c_d = '0;
        cap_r_d = (cap_r_q == CW'(N - 1)) ? '0 : cap_r_q + CW'(1);
      end else begin
        cap_c_d = cap_c_q + CW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          rd_en_d   = 1'b1;
          rd_addr_d = base_addr;
          issue_d   = IW'(1);
          cap_r_d   = '0;
          cap_c_d   = '0;
          t_d       = '0;
        end
      end
      S_LOAD: begin
        if (issue_q == IW'(NN)) begin
          state_d = S_STREAM;
          t_d     = '0;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          issue_d   = issue_q + IW'(1);
        end
      end
      S_STREAM: begin
        if (!stall) begin
          if (t_q == TW'(S - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            t_d     = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      issue_q   <= '0;
      rd_pend_q <= 1'b0;
      cap_r_q   <= '0;
      cap_c_q   <= '0;
      t_q       <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      issue_q   <= issue_d;
      rd_pend_q <= rd_pend_d;
      cap_r_q   <= cap_r_d;
      cap_c_q   <= cap_c_d;
      t_q       <= t_d;
      done_q    <= done_d;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [DATA_W-1:0] elem_q, elem_d;

      always_comb begin
        elem_d = elem_q;
        if (rd_pend_q && cap_r_q == CW'(gi) && cap_c_q == CW'(gj)) elem_d = elem_in;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) elem_q <= '0;
        else       elem_q <= elem_d;
      end

      assign tile[gi][gj] = elem_q;
    end
  end

  // Lane gi shows tile[gi][t-gi] while that column exists; the value follows t, so a stall holds it.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [DATA_W-1:0] lane_val;

    always_comb begin
      lane_val = '0;
      if (state_q == S_STREAM) begin
        for (int c = 0; c < N; c++) begin
          if (t_q == TW'(gi + c)) lane_val = tile[gi][c];
        end
      end
    end

    assign a_out[gi*DATA_W +: DATA_W] = lane_val;
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign a_valid = (state_q == S_STREAM) && !stall;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;

endmodule
